mac_seq_ctrl: RTL

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

---
 rtl/mac_seq_ctrl_pkg.sv | 22 ++
 rtl/mac_seq_ctrl_if.sv | 59 +++++
 rtl/mac_seq_addr_gen.sv | 69 ++++++
 rtl/mac_seq_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mac_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mac_seq_ctrl_pkg
// Shared definitions for the MAC dot-product sequencer:
//   - state_e      : sequencer FSM states
//   - PIPE_LAT_DEF : default MAC pipeline latency (enabled pair -> mac_acc)
//   - OP_W / ACC_W : operand and accumulator widths
// -----------------------------------------------------------------------------
package mac_seq_ctrl_pkg;

  localparam int PIPE_LAT_DEF = 4;
  localparam int OP_W         = 16;
  localparam int ACC_W        = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// mac_seq_ctrl_if
// Bundles every non-clock signal of the sequencer.
//   cmd_*  : dot-product command (bases, pair count), valid/ready
//   mem_*  : operand memory read port (data valid one cycle after mem_rd_en)
//   mac_*  : drive side of the external MAC plus its accumulator readback
//   res_*  : result, valid/ready
//   busy   : sequencer not idle
// Modports: slave = sequencer view, master = environment view.
//
// Handshake rule for cmd_* and res_*: a transfer happens on a rising clk edge
// where valid and ready are both 1; the producer holds valid and its payload
// stable until that edge, and ready may depend on state but never on valid.
// -----------------------------------------------------------------------------
interface mac_seq_ctrl_if
  import mac_seq_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8
);

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [ADDR_W-1:0]       cmd_a_base;
  logic [ADDR_W-1:0]       cmd_b_base;
  logic [ADDR_W-1:0]       cmd_len;

  logic                    mem_rd_en;
  logic [ADDR_W-1:0]       mem_a_addr;
  logic [ADDR_W-1:0]       mem_b_addr;
  logic signed [OP_W-1:0]  mem_a_data;
  logic signed [OP_W-1:0]  mem_b_data;

  logic signed [OP_W-1:0]  mac_a;
  logic signed [OP_W-1:0]  mac_b;
  logic                    mac_en;
  logic                    mac_clr;
  logic signed [ACC_W-1:0] mac_acc;

  logic                    res_valid;
  logic                    res_ready;
  logic signed [ACC_W-1:0] res_data;

  logic                    busy;

  modport slave (
    input  cmd_valid, cmd_a_base, cmd_b_base, cmd_len,
    input  mem_a_data, mem_b_data, mac_acc, res_ready,
    output cmd_ready, mem_rd_en, mem_a_addr, mem_b_addr,
    output mac_a, mac_b, mac_en, mac_clr, res_valid, res_data, busy
  );

  modport master (
    output cmd_valid, cmd_a_base, cmd_b_base, cmd_len,
    output mem_a_data, mem_b_data, mac_acc, res_ready,
    input  cmd_ready, mem_rd_en, mem_a_addr, mem_b_addr,
    input  mac_a, mac_b, mac_en, mac_clr, res_valid, res_data, busy
  );

endinterface

// File: rtl/mac_seq_addr_gen.sv
// -----------------------------------------------------------------------------
// mac_seq_addr_gen
// Latches the operand base addresses and pair count on load, then on every
// step advances both addresses (wrapping modulo 2^ADDR_W) and decrements the
// remaining-pair count.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   load_i              : latch a_base_i/b_base_i/len_i
//   a_base_i, b_base_i  : operand base addresses
//   len_i               : number of pairs
//   step_i              : one read issued this cycle
//   a_addr_o, b_addr_o  : current read addresses
//   len_zero_o          : no pairs remain
//   last_o              : exactly one pair remains (current step is the last)
// -----------------------------------------------------------------------------
module mac_seq_addr_gen #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] a_base_i,
  input  logic [ADDR_W-1:0] b_base_i,
  input  logic [ADDR_W-1:0] len_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] a_addr_o,
  output logic [ADDR_W-1:0] b_addr_o,
  output logic              len_zero_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] a_q, a_d;
  logic [ADDR_W-1:0] b_q, b_d;
  logic [ADDR_W-1:0] rem_q, rem_d;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    rem_d = rem_q;
    if (load_i) begin
      a_d   = a_base_i;
      b_d   = b_base_i;
      rem_d = len_i;
    end else if (step_i) begin
      // Natural overflow of the ADDR_W-bit add gives the modulo wrap.
      a_d   = a_q + ADDR_W'(1);
      b_d   = b_q + ADDR_W'(1);
      rem_d = rem_q - ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      rem_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      rem_q <= rem_d;
    end
  end

  assign a_addr_o   = a_q;
  assign b_addr_o   = b_q;
  assign len_zero_o = (rem_q == '0);
  assign last_o     = (rem_q == ADDR_W'(1));

endmodule

// File: rtl/mac_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mac_seq_ctrl
// Sequences a dot product over two operand vectors in memory through an
// external pipelined MAC: clear the MAC, stream len operand pairs, drain the
// MAC pipeline with zero pairs, capture the accumulator, hand out the result.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : cmd / mem / mac / res / busy signals, see mac_seq_ctrl_if
//   state_dbg_o   : current FSM state
//   perf_cmds     : (MAC_SEQ_PERF_EN) commands completed, saturating
//   perf_stall    : (MAC_SEQ_PERF_EN) DONE cycles with res_ready low, saturating
// Build option: define MAC_SEQ_PERF_EN to add the performance counters.
// -----------------------------------------------------------------------------
module mac_seq_ctrl
  import mac_seq_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  mac_seq_ctrl_if.slave     bus,
  output state_e            state_dbg_o
`ifdef MAC_SEQ_PERF_EN
  ,
  output logic [15:0]       perf_cmds,
  output logic [15:0]       perf_stall
`endif
);

  localparam int DCNT_W = $clog2(PIPE_LAT + 2);

  state_e              state_q, state_d;
  logic [DCNT_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic                en_q;
  logic signed [ACC_W-1:0] res_data_q, res_data_d;

  logic                cmd_hs;
  logic                drain_last;
  logic                len_zero;
  logic                issue_last;
  logic                rd_en;

  assign cmd_hs     = bus.cmd_valid && (state_q == S_IDLE);
  assign drain_last = (state_q == S_DRAIN) && (drain_cnt_q == DCNT_W'(PIPE_LAT));

  mac_seq_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cmd_hs),
    .a_base_i   (bus.cmd_a_base),
    .b_base_i   (bus.cmd_b_base),
    .len_i      (bus.cmd_len),
    .step_i     (rd_en),
    .a_addr_o   (bus.mem_a_addr),
    .b_addr_o   (bus.mem_b_addr),
    .len_zero_o (len_zero),
    .last_o     (issue_last)
  );

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= '0;
      en_q        <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      en_q        <= rd_en;
      res_data_q  <= res_data_d;
    end
  end

  // Next-state and datapath next values.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = '0;
    res_data_d  = res_data_q;
    case (state_q)
      S_IDLE:  if (cmd_hs) state_d = S_CLEAR;
      S_CLEAR: begin
        if (len_zero) begin
          state_d    = S_DONE;
          res_data_d = '0;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: if (issue_last) state_d = S_DRAIN;
      S_DRAIN: begin
        // Counts PIPE_LAT+1 cycles; the last real pair entered the MAC on the
        // first of them, so its contribution is on mac_acc in the final one.
        drain_cnt_d = drain_cnt_q + DCNT_W'(1);
        if (drain_last) begin
          state_d    = S_DONE;
          res_data_d = bus.mac_acc;
        end
      end
      S_DONE:  if (bus.res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    rd_en         = (state_q == S_ISSUE);
    bus.cmd_ready = (state_q == S_IDLE);
    bus.mem_rd_en = rd_en;
    bus.mac_clr   = rst || (state_q == S_CLEAR);
    // In DRAIN the enable stays up but operands are forced to zero once the
    // delayed read enable drops, so only zero products enter the pipeline.
    bus.mac_en    = en_q || (state_q == S_DRAIN);
    bus.mac_a     = en_q ? bus.mem_a_data : '0;
    bus.mac_b     = en_q ? bus.mem_b_data : '0;
    bus.res_valid = (state_q == S_DONE);
    bus.res_data  = res_data_q;
    bus.busy      = (state_q != S_IDLE);
    state_dbg_o   = state_q;
  end

`ifdef MAC_SEQ_PERF_EN
  logic [15:0] perf_cmds_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cmds_q  <= '0;
      perf_stall_q <= '0;
    end else if (state_q == S_DONE) begin
      if (bus.res_ready && (perf_cmds_q != 16'hFFFF))
        perf_cmds_q <= perf_cmds_q + 16'd1;
      if (!bus.res_ready && (perf_stall_q != 16'hFFFF))
        perf_stall_q <= perf_stall_q + 16'd1;
    end
  end

  assign perf_cmds  = perf_cmds_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule
